alu_decode_execute: RTL and testbench

Decode/execute core of the 16-bit I2O2 processor: decodes a fetched 16-bit instruction word, drives register-bank read addresses, computes the result in a 16-operation ALU and presents a registered write-back (address, data, enable) to the register bank. It sits between the fetch unit (instruction source) and the register bank (operand source and write-back target). Two-stage pipeline: Decode, then Execute; one instruction per cycle.

---
 rtl/alu_decode_execute.sv | 107 ++++++++++
 tb/tb_alu_decode_execute.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_execute.sv
// Decode/execute core of the 16-bit I2O2 processor: a registered Decode stage feeding a
// 16-operation combinational ALU, with results captured in a registered Execute/write-back stage.
module alu_decode_execute (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [15:0] palavra,
  input  logic [15:0] readData1,
  input  logic [15:0] readData2,
  output logic [3:0]  endereco_r1,
  output logic [3:0]  endereco_r2,
  output logic        in_read,
  output logic [3:0]  endereco_r3,
  output logic [15:0] saida_alu,
  output logic        in_write,
  output logic        zero,
  output logic        carry
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
    OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_NOT  = 4'h6, OP_SLL  = 4'h7,
    OP_SRL  = 4'h8, OP_SRA  = 4'h9, OP_ADDI = 4'hA, OP_SUBI = 4'hB,
    OP_SLT  = 4'hC, OP_LI   = 4'hD, OP_MOV  = 4'hE, OP_RSVD = 4'hF
  } opcode_e;

  opcode_e             d_codop;
  logic [ADDR_W-1:0]   d_rd;

  logic [DATA_W-1:0]   imm_ext_c;
  logic [DATA_W-1:0]   operand_b_c;
  logic [DATA_W:0]     sum_c;
  logic [DATA_W-1:0]   alu_result_c;
  logic                alu_carry_c;
  logic                writes_c;

  // Decode register; the rs2 field doubles as the 4-bit immediate and as the shift amount.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_codop     <= OP_NOP;
      d_rd        <= '0;
      endereco_r1 <= '0;
      endereco_r2 <= '0;
      in_read     <= 1'b0;
    end else begin
      d_codop     <= opcode_e'(palavra[15:12]);
      d_rd        <= palavra[11:8];
      endereco_r1 <= palavra[7:4];
      endereco_r2 <= palavra[3:0];
      in_read     <= instr_valid;
    end
  end

  // The ADD/SUB datapath is shared between the register and immediate forms.
  always_comb begin
    imm_ext_c    = DATA_W'(endereco_r2);
    operand_b_c  = ((d_codop == OP_ADDI) || (d_codop == OP_SUBI)) ? imm_ext_c : readData2;
    sum_c        = {1'b0, readData1} + {1'b0, operand_b_c};
    alu_result_c = '0;
    alu_carry_c  = 1'b0;
    case (d_codop)
      OP_ADD, OP_ADDI: begin
        alu_result_c = sum_c[DATA_W-1:0];
        alu_carry_c  = sum_c[DATA_W];
      end
      OP_SUB, OP_SUBI: begin
        alu_result_c = readData1 - operand_b_c;
        alu_carry_c  = (readData1 < operand_b_c);
      end
      OP_AND:  alu_result_c = readData1 & readData2;
      OP_OR:   alu_result_c = readData1 | readData2;
      OP_XOR:  alu_result_c = readData1 ^ readData2;
      OP_NOT:  alu_result_c = ~readData1;
      OP_SLL:  alu_result_c = readData1 << endereco_r2;
      OP_SRL:  alu_result_c = readData1 >> endereco_r2;
      OP_SRA:  alu_result_c = $unsigned($signed(readData1) >>> endereco_r2);
      OP_SLT:  alu_result_c = DATA_W'($signed(readData1) < $signed(readData2));
      OP_LI:   alu_result_c = imm_ext_c;
      OP_MOV:  alu_result_c = readData1;
      default: alu_result_c = '0;
    endcase
    writes_c = in_read && (d_codop != OP_NOP) && (d_codop != OP_RSVD);
  end

  // Execute register; bubbles keep the last result and destination but never write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      endereco_r3 <= '0;
      saida_alu   <= '0;
      in_write    <= 1'b0;
      zero        <= 1'b0;
      carry       <= 1'b0;
    end else begin
      in_write <= writes_c;
      if (in_read) begin
        endereco_r3 <= d_rd;
        saida_alu   <= alu_result_c;
        zero        <= (alu_result_c == '0);
        carry       <= alu_carry_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_decode_execute.sv
// Directed bench for alu_decode_execute: a constant register-bank model supplies operands,
// and every result is compared against hand-computed values.
module tb_alu_decode_execute;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [15:0] palavra;
  logic [15:0] readData1;
  logic [15:0] readData2;
  logic [3:0]  endereco_r1;
  logic [3:0]  endereco_r2;
  logic        in_read;
  logic [3:0]  endereco_r3;
  logic [15:0] saida_alu;
  logic        in_write;
  logic        zero;
  logic        carry;

  logic [15:0] regs [16];
  int n_cmp = 0;
  int n_err = 0;

  alu_decode_execute dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .palavra     (palavra),
    .readData1   (readData1),
    .readData2   (readData2),
    .endereco_r1 (endereco_r1),
    .endereco_r2 (endereco_r2),
    .in_read     (in_read),
    .endereco_r3 (endereco_r3),
    .saida_alu   (saida_alu),
    .in_write    (in_write),
    .zero        (zero),
    .carry       (carry)
  );

  always #5 clock = ~clock;

  // Fixed register contents; write-backs are observed, not applied.
  assign readData1 = regs[endereco_r1];
  assign readData2 = regs[endereco_r2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one input slot at the falling edge, return 1 ns after the next rising edge.
  task automatic cycle(input logic v, input logic [15:0] w);
    @(negedge clock);
    instr_valid = v;
    palavra     = w;
    @(posedge clock);
    #1;
  endtask

  // Issue one instruction followed by a bubble, then check the write-back.
  task automatic exec(input string tag, input logic [15:0] w, input logic [15:0] res,
                      input logic wr, input logic c);
    cycle(1'b1, w);
    cycle(1'b0, 16'h0000);
    chk({tag, ".data"},  saida_alu, res);
    chk({tag, ".wr"},    16'(in_write), 16'(wr));
    chk({tag, ".carry"}, 16'(carry), 16'(c));
    chk({tag, ".zero"},  16'(zero), 16'(res == 16'h0000));
    chk({tag, ".rd"},    16'(endereco_r3), 16'(w[11:8]));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    regs[1] = 16'hFFFF; regs[2] = 16'h0001; regs[4] = 16'h0005;
    regs[5] = 16'h0007; regs[6] = 16'h8000; regs[7] = 16'h8001;
    reset_n = 1'b0; instr_valid = 1'b0; palavra = 16'h0000;
    #12;
    chk("rst.in_read",  16'(in_read), 16'h0);
    chk("rst.in_write", 16'(in_write), 16'h0);
    chk("rst.saida",    saida_alu, 16'h0000);
    chk("rst.r3",       16'(endereco_r3), 16'h0);
    chk("rst.r1",       16'(endereco_r1), 16'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // ADD wrapping to zero with carry out; decode addresses checked one cycle in.
    cycle(1'b1, 16'h1312);
    chk("add.in_read", 16'(in_read), 16'h1);
    chk("add.r1",      16'(endereco_r1), 16'h1);
    chk("add.r2",      16'(endereco_r2), 16'h2);
    cycle(1'b0, 16'h0000);
    chk("add.data",  saida_alu, 16'h0000);
    chk("add.zero",  16'(zero), 16'h1);
    chk("add.carry", 16'(carry), 16'h1);
    chk("add.rd",    16'(endereco_r3), 16'h3);
    chk("add.wr",    16'(in_write), 16'h1);

    exec("add2", 16'h1145, 16'h000C, 1'b1, 1'b0);
    exec("sub",  16'h2145, 16'hFFFE, 1'b1, 1'b1);
    exec("subz", 16'h2A44, 16'h0000, 1'b1, 1'b0);
    exec("slt1", 16'hC145, 16'h0001, 1'b1, 1'b0);
    exec("slt2", 16'hC162, 16'h0001, 1'b1, 1'b0);
    exec("slt3", 16'hC154, 16'h0000, 1'b1, 1'b0);
    exec("and",  16'h3145, 16'h0005, 1'b1, 1'b0);
    exec("or",   16'h4145, 16'h0007, 1'b1, 1'b0);
    exec("xor",  16'h5145, 16'h0002, 1'b1, 1'b0);
    exec("not",  16'h6140, 16'hFFFA, 1'b1, 1'b0);
    exec("sll4", 16'h7174, 16'h0010, 1'b1, 1'b0);
    exec("srl1", 16'h8171, 16'h4000, 1'b1, 1'b0);
    exec("sra1", 16'h9171, 16'hC000, 1'b1, 1'b0);
    exec("sra0", 16'h9170, 16'h8001, 1'b1, 1'b0);
    exec("sll0", 16'h7170, 16'h8001, 1'b1, 1'b0);
    exec("srl0", 16'h8170, 16'h8001, 1'b1, 1'b0);
    exec("addi", 16'hA11F, 16'h000E, 1'b1, 1'b1);
    exec("subi1", 16'hB121, 16'h0000, 1'b1, 1'b0);
    exec("subi2", 16'hB122, 16'hFFFF, 1'b1, 1'b1);
    exec("mov",  16'hE870, 16'h8001, 1'b1, 1'b0);

    // Back-to-back ADDI, LI, NOP, F.
    cycle(1'b1, 16'hA34F);
    cycle(1'b1, 16'hD509);
    chk("b2b.addi.data", saida_alu, 16'h0014);
    chk("b2b.addi.wr",   16'(in_write), 16'h1);
    chk("b2b.addi.rd",   16'(endereco_r3), 16'h3);
    cycle(1'b1, 16'h0000);
    chk("b2b.li.data", saida_alu, 16'h0009);
    chk("b2b.li.wr",   16'(in_write), 16'h1);
    chk("b2b.li.rd",   16'(endereco_r3), 16'h5);
    cycle(1'b1, 16'hF000);
    chk("b2b.nop.wr",  16'(in_write), 16'h0);
    cycle(1'b0, 16'h0000);
    chk("b2b.f.wr",    16'(in_write), 16'h0);
    chk("b2b.f.in_read", 16'(in_read), 16'h0);

    // instr_valid 1,0,1,0: in_read follows one cycle later, in_write one further.
    cycle(1'b1, 16'h1645);
    chk("tog1.in_read", 16'(in_read), 16'h1);
    cycle(1'b0, 16'h1111);
    chk("tog2.in_read", 16'(in_read), 16'h0);
    chk("tog2.wr",      16'(in_write), 16'h1);
    chk("tog2.data",    saida_alu, 16'h000C);
    cycle(1'b1, 16'hE740);
    chk("tog3.in_read", 16'(in_read), 16'h1);
    chk("tog3.wr",      16'(in_write), 16'h0);
    chk("tog3.hold",    saida_alu, 16'h000C);
    chk("tog3.rdhold",  16'(endereco_r3), 16'h6);
    cycle(1'b0, 16'h0000);
    chk("tog4.in_read", 16'(in_read), 16'h0);
    chk("tog4.wr",      16'(in_write), 16'h1);
    chk("tog4.data",    saida_alu, 16'h0005);
    chk("tog4.rd",      16'(endereco_r3), 16'h7);
    cycle(1'b0, 16'h0000);
    chk("tog5.wr",      16'(in_write), 16'h0);

    // Asynchronous reset with an ADD in Execute and another in Decode.
    cycle(1'b1, 16'h1312);
    cycle(1'b1, 16'h1145);
    chk("mid.wr_before", 16'(in_write), 16'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid.wr",      16'(in_write), 16'h0);
    chk("mid.in_read", 16'(in_read), 16'h0);
    chk("mid.saida",   saida_alu, 16'h0000);
    chk("mid.r3",      16'(endereco_r3), 16'h0);
    chk("mid.r1",      16'(endereco_r1), 16'h0);
    chk("mid.carry",   16'(carry), 16'h0);
    chk("mid.zero",    16'(zero), 16'h0);
    instr_valid = 1'b1;
    palavra     = 16'h1145;
    @(posedge clock);
    #1;
    chk("mid.held_wr", 16'(in_write), 16'h0);
    chk("mid.held_rd", 16'(in_read), 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
    exec("post", 16'hD20A, 16'h000A, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
